// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped GPIO block: register word offsets
// and the byte-lane write mask helper.
package mmio_pkg;

   localparam logic [2:0] GPIO_OUT     = 3'd0;
   localparam logic [2:0] GPIO_OE      = 3'd1;
   localparam logic [2:0] GPIO_IN      = 3'd2;
   localparam logic [2:0] GPIO_RISE_EN = 3'd3;
   localparam logic [2:0] GPIO_FALL_EN = 3'd4;
   localparam logic [2:0] GPIO_PEND    = 3'd5;
   localparam logic [2:0] GPIO_SET     = 3'd6;
   localparam logic [2:0] GPIO_CLR     = 3'd7;

   // Expand per-byte write enables into a 32-bit bit mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] we);
      return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   endfunction

endpackage

// File: rtl/mmio_gpio_if.sv
// CPU data-bus slice seen by the GPIO block: decoder select, word offset,
// read strobe, byte-lane write enables, write data and registered read data.
interface mmio_gpio_if;

   logic        sel;
   logic [2:0]  addr;
   logic        re;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output addr, output re, output we, output wdata,
                   input rdata);

   modport slave (input sel, input addr, input re, input we, input wdata,
                  output rdata);

endinterface

// File: rtl/sync_edge.sv
// Input synchroniser for the GPIO pads. With MMIO_GPIO_IRQ_EN defined it also
// keeps the previous synchronised value and a priming counter, and reports
// rise/fall events once the chain has flushed its reset contents.
module sync_edge #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync
`ifdef MMIO_GPIO_IRQ_EN
   ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`endif
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   // Shift pad values through the synchroniser chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef MMIO_GPIO_IRQ_EN
   localparam int unsigned PrimeMax = SYNC_STAGES + 1;
   localparam int unsigned CntW     = $clog2(PrimeMax + 1);

   logic [WIDTH-1:0] prev_q;
   logic [CntW-1:0]  prime_q;
   logic             primed;

   assign primed = (prime_q == CntW'(PrimeMax));

   // Track the previous sample and count out the priming window after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q  <= '0;
         prime_q <= '0;
      end else begin
         prev_q <= sync;
         if (!primed) prime_q <= prime_q + 1'b1;
      end
   end

   // Pins already high at reset release must not look like rising edges.
   assign rise = primed ? (sync & ~prev_q) : '0;
   assign fall = primed ? (~sync & prev_q) : '0;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO peripheral: output register with set/clear aliases,
// per-bit output enable, synchronised inputs. Defining MMIO_GPIO_IRQ_EN adds
// rise/fall enables, W1C pending bits and a registered level interrupt.
module mmio_gpio
   import mmio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   mmio_gpio_if.slave       bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic             wr_en;
   logic             rd_en;
   logic [31:0]      mask_full;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] wbits;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] oe_q, oe_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      rd_val;
   logic             unused_hi;

   assign wr_en     = bus.sel & (|bus.we);
   assign rd_en     = bus.sel & bus.re;
   assign mask_full = byte_mask(bus.we);
   assign mask      = mask_full[WIDTH-1:0];
   assign wbits     = bus.wdata[WIDTH-1:0] & mask;
   // Register bits above WIDTH do not exist.
   assign unused_hi = ^{bus.wdata, mask_full};

`ifdef MMIO_GPIO_IRQ_EN
   logic [WIDTH-1:0] rise, fall;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             irq_q;
`endif

   sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk   (clk),
      .reset (reset),
      .din   (gpio_in),
      .sync  (in_sync)
`ifdef MMIO_GPIO_IRQ_EN
      ,
      .rise  (rise),
      .fall  (fall)
`endif
   );

   // Next state of the output and output-enable registers.
   always_comb begin
      out_d = out_q;
      oe_d  = oe_q;
      if (wr_en) begin
         case (bus.addr)
            GPIO_OUT: out_d = (out_q & ~mask) | wbits;
            GPIO_OE:  oe_d  = (oe_q & ~mask) | wbits;
            GPIO_SET: out_d = out_q | wbits;
            GPIO_CLR: out_d = out_q & ~wbits;
            default:  ;
         endcase
      end
   end

`ifdef MMIO_GPIO_IRQ_EN
   // Next state of the interrupt enables and pending bits; a new event beats W1C.
   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      pend_d    = pend_q;
      if (wr_en) begin
         case (bus.addr)
            GPIO_RISE_EN: rise_en_d = (rise_en_q & ~mask) | wbits;
            GPIO_FALL_EN: fall_en_d = (fall_en_q & ~mask) | wbits;
            GPIO_PEND:    pend_d    = pend_q & ~wbits;
            default:      ;
         endcase
      end
      pend_d = pend_d | (rise & rise_en_q) | (fall & fall_en_q);
   end
`endif

   // Read mux; values reflect register contents before any same-cycle write.
   always_comb begin
      rd_val = '0;
      case (bus.addr)
         GPIO_OUT:     rd_val[WIDTH-1:0] = out_q;
         GPIO_OE:      rd_val[WIDTH-1:0] = oe_q;
         GPIO_IN:      rd_val[WIDTH-1:0] = in_sync;
`ifdef MMIO_GPIO_IRQ_EN
         GPIO_RISE_EN: rd_val[WIDTH-1:0] = rise_en_q;
         GPIO_FALL_EN: rd_val[WIDTH-1:0] = fall_en_q;
         GPIO_PEND:    rd_val[WIDTH-1:0] = pend_q;
`endif
         default:      ;
      endcase
      rdata_d = rd_en ? rd_val : rdata_q;
   end

   // Bus-visible register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q   <= '0;
         oe_q    <= '0;
         rdata_q <= '0;
      end else begin
         out_q   <= out_d;
         oe_q    <= oe_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MMIO_GPIO_IRQ_EN
   // Interrupt state; irq follows pending bits by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         irq_q     <= |pend_q;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign bus.rdata = rdata_q;
   assign gpio_out  = out_q;
   assign gpio_oe   = oe_q;

endmodule
